// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue instruction fetch front end.
package fetch_pkg;

  // Size of one instruction word in bytes; PCs advance in multiples of this.
  localparam int INST_BYTES = 4;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // IDLE: no request outstanding. WAIT: request outstanding and wanted.
  // DROP: request outstanding but its response belongs to a flushed path.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // Number of words carried by an accepted response. A missing first word
  // makes the whole response unusable, so the second word is then ignored.
  function automatic logic [1:0] resp_words(input logic ok_1, input logic ok_2);
    logic [1:0] words;
    if (!ok_1) begin
      words = 2'd0;
    end else if (ok_2) begin
      words = 2'd2;
    end else begin
      words = 2'd1;
    end
    return words;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction buffer with two write ports and two read ports.
// Per cycle it retires 0-2 entries from the head, then appends 0-2 at the tail.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic [1:0]             push_count_i,
  input  fetch_entry_t           push_0_i,
  input  fetch_entry_t           push_1_i,
  input  logic [1:0]             pop_count_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   valid_1_o,
  output logic                   valid_2_o,
  output fetch_entry_t           head_0_o,
  output fetch_entry_t           head_1_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] head_p1, tail_p1;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_0, wr_1;

  // Pointers are a power-of-two wide, so natural overflow gives the wrap.
  assign head_p1 = head_q + PTR_W'(1);
  assign tail_p1 = tail_q + PTR_W'(1);
  assign wr_0    = !flush_i && (push_count_i != 2'd0);
  assign wr_1    = !flush_i && (push_count_i == 2'd2);

  // Pointer and occupancy next state: pop first, then push; flush overrides both.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(pop_count_i);
      tail_d  = tail_q + PTR_W'(push_count_i);
      count_d = count_q - CNT_W'(pop_count_i) + CNT_W'(push_count_i);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage writes at the tail and tail+1.
  // NOTE: storage is deliberately not reset; occupancy decides validity and the
  // read side zeroes invalid slots, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (wr_0) begin
      mem_q[tail_q] <= push_0_i;
    end
    if (wr_1) begin
      mem_q[tail_p1] <= push_1_i;
    end
  end

  assign count_o   = count_q;
  assign valid_1_o = (count_q != '0);
  assign valid_2_o = (count_q > CNT_W'(1));
  assign head_0_o  = valid_1_o ? mem_q[head_q]  : '0;
  assign head_1_o  = valid_2_o ? mem_q[head_p1] : '0;

endmodule

// File: rtl/inst_fetch.sv
// Dual-issue instruction fetch front end. Issues one request at a time to the
// MMU instruction channel, buffers returned words with their PCs, presents up
// to two per cycle to decode, and handles redirects including in-flight drops.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_en,
  output logic [31:0] inst_addr,
  input  logic        inst_ok,
  input  logic        inst_ok_1,
  input  logic        inst_ok_2,
  input  logic [31:0] inst_data_1,
  input  logic [31:0] inst_data_2,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid_1,
  output logic        out_valid_2,
  output logic [31:0] out_inst_1,
  output logic [31:0] out_pc_1,
  output logic [31:0] out_inst_2,
  output logic [31:0] out_pc_2,
  input  logic [1:0]  pop_count
);

  localparam int               CNT_W     = $clog2(FIFO_DEPTH) + 1;
  // A new request may go out only if two slots stay free after this cycle.
  localparam logic [CNT_W-1:0] ISSUE_MAX = CNT_W'(FIFO_DEPTH - 2);

  fetch_state_t     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             inst_en_q, inst_en_d;
  logic [31:0]      inst_addr_q, inst_addr_d;

  logic [31:0]      target_pc;
  logic [31:0]      pc_adv;
  logic             accept;
  logic [1:0]       push_cnt;
  logic [1:0]       pop_eff;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] count_after;
  logic             issue_ok;
  fetch_entry_t     push_0, push_1;
  fetch_entry_t     head_0, head_1;

  // Redirect targets are always word aligned.
  assign target_pc = {redirect_pc[31:2], 2'b00};

  // A response is kept only when it answers a live request and no flush is pending.
  assign accept   = (state_q == WAIT) && inst_ok && !redirect_valid;
  assign push_cnt = accept ? resp_words(inst_ok_1, inst_ok_2) : 2'd0;
  assign pop_eff  = redirect_valid ? 2'd0 : pop_count;
  assign pc_adv   = pc_q + (32'(push_cnt) * 32'(INST_BYTES));

  // In WAIT the outstanding address always equals pc, so pc tags the pushed words.
  assign push_0 = '{pc: pc_q,                    inst: inst_data_1};
  assign push_1 = '{pc: pc_q + 32'(INST_BYTES),  inst: inst_data_2};

  // Occupancy as it will be after this cycle's pop and push.
  assign count_after = redirect_valid ? '0
                     : fifo_count - CNT_W'(pop_eff) + CNT_W'(push_cnt);
  assign issue_ok    = (count_after <= ISSUE_MAX);

  // Request FSM and pc update; redirect takes priority over everything else.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_en_d   = inst_en_q;
    inst_addr_d = inst_addr_q;

    if (redirect_valid) begin
      pc_d = target_pc;
      case (state_q)
        IDLE: begin
          state_d     = WAIT;
          inst_en_d   = 1'b1;
          inst_addr_d = target_pc;
        end
        WAIT, DROP: begin
          if (inst_ok) begin
            // The in-flight response ends here and is discarded; refetch at once.
            state_d     = WAIT;
            inst_en_d   = 1'b1;
            inst_addr_d = target_pc;
          end else begin
            // Old request still outstanding: keep it on the bus and drop its answer.
            state_d = DROP;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (issue_ok) begin
            state_d     = WAIT;
            inst_en_d   = 1'b1;
            inst_addr_d = pc_q;
          end
        end
        WAIT: begin
          if (inst_ok) begin
            pc_d = pc_adv;
            if (issue_ok) begin
              inst_en_d   = 1'b1;
              inst_addr_d = pc_adv;
            end else begin
              state_d   = IDLE;
              inst_en_d = 1'b0;
            end
          end
        end
        DROP: begin
          if (inst_ok) begin
            state_d     = WAIT;
            inst_en_d   = 1'b1;
            inst_addr_d = pc_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state, pc and request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      inst_en_q   <= 1'b0;
      inst_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_en_q   <= inst_en_d;
      inst_addr_q <= inst_addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst),
    .flush_i      (redirect_valid),
    .push_count_i (push_cnt),
    .push_0_i     (push_0),
    .push_1_i     (push_1),
    .pop_count_i  (pop_eff),
    .count_o      (fifo_count),
    .valid_1_o    (out_valid_1),
    .valid_2_o    (out_valid_2),
    .head_0_o     (head_0),
    .head_1_o     (head_1)
  );

  assign inst_en    = inst_en_q;
  assign inst_addr  = inst_addr_q;
  assign out_inst_1 = head_0.inst;
  assign out_pc_1   = head_0.pc;
  assign out_inst_2 = head_1.inst;
  assign out_pc_2   = head_1.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: acts as the MMU and as decode, and compares
// outputs against hand-computed values one cycle at a time.
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_en;
  logic [31:0] inst_addr;
  logic        inst_ok, inst_ok_1, inst_ok_2;
  logic [31:0] inst_data_1, inst_data_2;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid_1, out_valid_2;
  logic [31:0] out_inst_1, out_pc_1, out_inst_2, out_pc_2;
  logic [1:0]  pop_count;

  int vectors     = 0;
  int miscompares = 0;

  inst_fetch #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .inst_en        (inst_en),
    .inst_addr      (inst_addr),
    .inst_ok        (inst_ok),
    .inst_ok_1      (inst_ok_1),
    .inst_ok_2      (inst_ok_2),
    .inst_data_1    (inst_data_1),
    .inst_data_2    (inst_data_2),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid_1    (out_valid_1),
    .out_valid_2    (out_valid_2),
    .out_inst_1     (out_inst_1),
    .out_pc_1       (out_pc_1),
    .out_inst_2     (out_inst_2),
    .out_pc_2       (out_pc_2),
    .pop_count      (pop_count)
  );

  always #5 clk = ~clk;

  // Decode must never consume more entries than are shown as valid.
  always @(posedge clk) begin
    if (rst) begin
      assert ({1'b0, pop_count} <= {2'b00, out_valid_1} + {2'b00, out_valid_2})
        else $error("illegal pop_count %0d", pop_count);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_ok        = 1'b0;
    inst_ok_1      = 1'b0;
    inst_ok_2      = 1'b0;
    inst_data_1    = '0;
    inst_data_2    = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    pop_count      = 2'd0;
  endtask

  task automatic respond(input logic ok_1, input logic ok_2,
                         input logic [31:0] d1, input logic [31:0] d2);
    inst_ok     = 1'b1;
    inst_ok_1   = ok_1;
    inst_ok_2   = ok_2;
    inst_data_1 = d1;
    inst_data_2 = d2;
  endtask

  task automatic expect_req(input string tag, input logic en, input logic [31:0] addr);
    check({tag, ".en"},   32'(inst_en), 32'(en));
    check({tag, ".addr"}, inst_addr,    addr);
  endtask

  // Entry contents are only compared where the slot is expected to be valid.
  task automatic expect_out(input string tag,
                            input logic v1, input logic [31:0] pc1, input logic [31:0] i1,
                            input logic v2, input logic [31:0] pc2, input logic [31:0] i2);
    check({tag, ".v1"}, 32'(out_valid_1), 32'(v1));
    check({tag, ".v2"}, 32'(out_valid_2), 32'(v2));
    if (v1) begin
      check({tag, ".pc1"},   out_pc_1,   pc1);
      check({tag, ".inst1"}, out_inst_1, i1);
    end
    if (v2) begin
      check({tag, ".pc2"},   out_pc_2,   pc2);
      check({tag, ".inst2"}, out_inst_2, i2);
    end
  endtask

  // Recognisable instruction word derived from its address.
  function automatic logic [31:0] dat(input logic [31:0] pc);
    return {16'hD00D, pc[15:0]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b0;
    repeat (3) tick();

    // Reset state.
    expect_req("reset", 1'b0, RST_PC);
    expect_out("reset", 1'b0, '0, '0, 1'b0, '0, '0);
    check("reset.inst1", out_inst_1, 32'h0);
    check("reset.pc1",   out_pc_1,   32'h0);
    check("reset.inst2", out_inst_2, 32'h0);
    check("reset.pc2",   out_pc_2,   32'h0);

    // First request one cycle after reset release, held while waiting.
    rst = 1'b1;
    tick();
    expect_req("first_req", 1'b1, RST_PC);
    tick();
    expect_req("first_hold", 1'b1, RST_PC);
    tick();

    // Dual response: both words visible next cycle, back-to-back request at +8.
    respond(1'b1, 1'b1, 32'h2400_0001, 32'h2400_0002);
    tick();
    idle_inputs();
    expect_out("dual", 1'b1, 32'hBFC0_0000, 32'h2400_0001, 1'b1, 32'hBFC0_0004, 32'h2400_0002);
    expect_req("dual_next", 1'b1, 32'hBFC0_0008);

    // Pop two while a single-word response arrives: one entry left, pc +4.
    pop_count = 2'd2;
    respond(1'b1, 1'b0, 32'h3C01_0008, JUNK);
    tick();
    idle_inputs();
    expect_out("single", 1'b1, 32'hBFC0_0008, 32'h3C01_0008, 1'b0, '0, '0);
    expect_req("single_next", 1'b1, 32'hBFC0_000C);

    // ok_1 low: nothing pushed, same address reissued.
    respond(1'b0, 1'b1, JUNK, JUNK);
    tick();
    idle_inputs();
    expect_req("retry", 1'b1, 32'hBFC0_000C);
    expect_out("retry", 1'b1, 32'hBFC0_0008, 32'h3C01_0008, 1'b0, '0, '0);

    respond(1'b1, 1'b1, 32'h2000_000C, 32'h2000_0010);
    tick();
    idle_inputs();
    expect_out("after_retry", 1'b1, 32'hBFC0_0008, 32'h3C01_0008,
               1'b1, 32'hBFC0_000C, 32'h2000_000C);
    expect_req("after_retry", 1'b1, 32'hBFC0_0014);

    pop_count = 2'd1;
    tick();
    idle_inputs();
    expect_out("pop1", 1'b1, 32'hBFC0_000C, 32'h2000_000C, 1'b1, 32'hBFC0_0010, 32'h2000_0010);
    expect_req("pop1", 1'b1, 32'hBFC0_0014);

    // Fill with no pops: at 6 entries one more request goes out, at 8 fetching stops.
    for (int k = 0; k < 3; k++) begin
      logic [31:0] pcw;
      pcw = 32'hBFC0_0014 + 32'(8 * k);
      respond(1'b1, 1'b1, dat(pcw), dat(pcw + 32'd4));
      tick();
      idle_inputs();
      if (k < 2) begin
        expect_req("fill", 1'b1, pcw + 32'd8);
      end else begin
        check("fill_full.en", 32'(inst_en), 32'd0);
      end
    end
    tick();
    check("full_idle.en", 32'(inst_en), 32'd0);
    expect_out("full_idle", 1'b1, 32'hBFC0_000C, 32'h2000_000C, 1'b1, 32'hBFC0_0010, 32'h2000_0010);

    // One cycle of pop 2 frees enough room to resume.
    pop_count = 2'd2;
    tick();
    idle_inputs();
    expect_req("resume", 1'b1, 32'hBFC0_002C);
    expect_out("resume", 1'b1, 32'hBFC0_0014, dat(32'hBFC0_0014),
               1'b1, 32'hBFC0_0018, dat(32'hBFC0_0018));

    respond(1'b1, 1'b1, dat(32'hBFC0_002C), dat(32'hBFC0_0030));
    tick();
    idle_inputs();
    check("full_again.en", 32'(inst_en), 32'd0);

    // Redirect with nothing in flight: new request and empty outputs next cycle.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h9000_0000;
    tick();
    idle_inputs();
    expect_req("redir_idle", 1'b1, 32'h9000_0000);
    expect_out("redir_idle", 1'b0, '0, '0, 1'b0, '0, '0);

    // Redirect while waiting: old request stays on the bus, its answer is dropped.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;
    tick();
    idle_inputs();
    expect_req("redir_wait", 1'b1, 32'h9000_0000);
    tick();
    expect_req("drop_hold", 1'b1, 32'h9000_0000);
    respond(1'b1, 1'b1, JUNK, JUNK);
    tick();
    idle_inputs();
    expect_req("drop_done", 1'b1, 32'h8000_0100);
    expect_out("drop_done", 1'b0, '0, '0, 1'b0, '0, '0);

    respond(1'b1, 1'b1, 32'hF000_0100, 32'hF000_0104);
    tick();
    idle_inputs();
    expect_out("post_drop", 1'b1, 32'h8000_0100, 32'hF000_0100,
               1'b1, 32'h8000_0104, 32'hF000_0104);
    expect_req("post_drop", 1'b1, 32'h8000_0108);

    // Redirect coinciding with a response and a pop: no push, refetch at target.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0004;
    pop_count      = 2'd2;
    respond(1'b1, 1'b1, JUNK, JUNK);
    tick();
    idle_inputs();
    expect_out("redir_ok", 1'b0, '0, '0, 1'b0, '0, '0);
    expect_req("redir_ok", 1'b1, 32'h8000_0004);

    respond(1'b1, 1'b0, 32'h1234_5678, JUNK);
    tick();
    idle_inputs();
    expect_out("single_004", 1'b1, 32'h8000_0004, 32'h1234_5678, 1'b0, '0, '0);
    expect_req("single_004", 1'b1, 32'h8000_0008);

    // A second redirect during DROP only retargets the eventual refetch.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h4000_0000;
    tick();
    idle_inputs();
    expect_req("drop_a", 1'b1, 32'h8000_0008);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h4000_0040;
    tick();
    idle_inputs();
    expect_req("drop_b", 1'b1, 32'h8000_0008);
    respond(1'b1, 1'b1, JUNK, JUNK);
    tick();
    idle_inputs();
    expect_req("drop_b_done", 1'b1, 32'h4000_0040);
    expect_out("drop_b_done", 1'b0, '0, '0, 1'b0, '0, '0);

    respond(1'b1, 1'b1, 32'h0BAD_F00D, 32'h0000_0013);
    tick();
    idle_inputs();
    expect_out("final", 1'b1, 32'h4000_0040, 32'h0BAD_F00D, 1'b1, 32'h4000_0044, 32'h0000_0013);
    expect_req("final", 1'b1, 32'h4000_0048);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Dual-issue instruction fetch front end that drives the instruction channel of `mmu_top` as its initiator. It requests instruction pairs from the MMU, consumes single or dual responses and buffers them with their PCs in a small FIFO. It presents up to two instructions per cycle to decode and handles branch/exception redirects, including discarding a response that is already in flight.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: fetch address after reset; low 2 bits must be 0.
- `FIFO_DEPTH`, default 8: entries in the instruction buffer; power of two, at least 4.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `inst_en` out 1: fetch request valid.
- `inst_addr` out 32: fetch address, word aligned.
- `inst_ok` in 1: response strobe for the outstanding request.
- `inst_ok_1` in 1: with `inst_ok`, the word at `inst_addr` is valid on `inst_data_1`.
- `inst_ok_2` in 1: with `inst_ok`, the word at `inst_addr+4` is valid on `inst_data_2`.
- `inst_data_1` in 32, `inst_data_2` in 32: returned instruction words.
- `redirect_valid` in 1: flush the pipeline and refetch.
- `redirect_pc` in 32: redirect target; bits [1:0] are forced to 0 internally.
- `out_valid_1` out 1, `out_valid_2` out 1: FIFO head, and head+1, are valid.
- `out_inst_1` out 32, `out_pc_1` out 32: instruction and PC at the head.
- `out_inst_2` out 32, `out_pc_2` out 32: instruction and PC at head+1.
- `pop_count` in 2: entries decode consumes this cycle.
  - Legal values are 0–2.
  - Must not exceed the number of valid outputs; violation is undefined (assertion in bench).

## Operation
- Registers: `pc`, FIFO occupancy `count`, and state in {IDLE, WAIT, DROP}.
- Protocol rule: at most one request is outstanding. `inst_en` and `inst_addr` are held stable from assertion until the cycle `inst_ok`=1 inclusive.
- Issue rule: a request is issued only when free slots are at least 2, computed as FIFO_DEPTH − count after this cycle's pop/push. This guarantees a dual response always fits.
- IDLE:
  - If the issue rule holds, the next cycle has `inst_en`=1, `inst_addr`=`pc`, and state WAIT.
  - Otherwise stay in IDLE.
- WAIT, `inst_ok`=1:
  - ok_1 and ok_2: push {pc, data_1} and {pc+4, data_2}; pc += 8.
  - ok_1 only: push {pc, data_1}; pc += 4.
  - ok_1=0 (ok_2 ignored): push nothing; pc is unchanged (retry).
  - Then, if the issue rule holds, stay in WAIT with `inst_en`=1 and the new pc, back-to-back. Otherwise go to IDLE with `inst_en`=0.
- Redirect, highest priority:
  - FIFO is flushed (count=0; pop is ignored).
  - pc <= redirect_pc.
  - Any response arriving in the same cycle is dropped.
  - From IDLE, or from WAIT with `inst_ok`=1: next state WAIT, `inst_en`=1, `inst_addr`=redirect_pc.
  - From WAIT with `inst_ok`=0: next state DROP; `inst_en` and `inst_addr` keep their old values.
- DROP:
  - The response on `inst_ok` is discarded.
  - Next state WAIT with `inst_addr`=pc.
  - A redirect while in DROP only updates pc; state stays DROP until `inst_ok`.
- Push and pop in the same cycle: pop is applied first, then push; the FIFO pointers wrap modulo FIFO_DEPTH.
- `count` width: clog2(FIFO_DEPTH)+1 bits.
- PC arithmetic: 32-bit modulo 2^32; wrap is not flagged.

## Timing
- Reset values: `inst_en`=0, `inst_addr`=RESET_PC, all `out_valid_*`=0, `out_inst_*`=0, `out_pc_*`=0, state IDLE, pc=RESET_PC, count=0.
- First request: `inst_en`=1 at the first rising edge after `rst` deasserts, i.e. 1 cycle of latency.
- Response to output: entries pushed at edge N appear on the outputs after edge N (a 1-cycle bypass is not provided). `out_pc_2` equals `out_pc_1`+4 only when the pair came from one dual response.
- Redirect with no request in flight: `inst_en`=1 with the new address in the cycle after the redirect, and `out_valid_*`=0 in that same cycle.
- Outputs are driven from registers/FIFO storage, with no combinational path from the `inst_*` inputs. `pop_count` affects only the next state.
- Reset asserted mid-request: all state clears immediately. The MMU must also be reset, and no response is expected afterwards.

## Structure
- Package `fetch_pkg`:
  - `fetch_entry_t` {pc[31:0], inst[31:0]};
  - `fetch_state_t` enum {IDLE, WAIT, DROP};
  - constant `INST_BYTES`=4.
- Sub-module `fetch_fifo`: a circular buffer of `fetch_entry_t` with 2 write ports and 2 read ports. It takes push_count 0–2 and pop_count 0–2, supports flush, and outputs count and head/head+1.
- `inst_fetch` contains the FSM, the pc register and the request logic.

## Test plan
- Reset release, MMU returns dual ok after 3 cycles: `inst_addr`=BFC0_0000, then the outputs show pc BFC0_0000 and BFC0_0004. The next request is issued at BFC0_0008 with `inst_en` held high.
- Single ok_1 at pc 0x...004: one entry is pushed, and the next `inst_addr` is 0x...008.
- `pop_count`=0 with FIFO_DEPTH=8: requests stop once count reaches 6 (with a pending dual, count ends at 8). `pop_count`=2 for one cycle resumes fetching.
- Redirect to 0x8000_0100 while in WAIT; `inst_ok` arrives 2 cycles later: the response is dropped and the FIFO stays empty. The next request is at 0x8000_0100 and the first output pc is 0x8000_0100.
- Redirect in the same cycle as `inst_ok` and `pop_count`=2: nothing is pushed and the outputs are invalid next cycle. The next cycle also has `inst_en`=1 with `inst_addr`=redirect_pc.
- `inst_ok`=1 with `inst_ok_1`=0: no push, and the same `inst_addr` is reissued.
